// File: rtl/decoder_pkg.sv
// Shared decode-stage types plus the LED PWM config word layout.
// Types: word (32b data), r (5b register index), csr_addr_t (12b), csr_t (CSR op).
// Also carries the PWM FSM state type and a config-field extraction helper.
package decoder_pkg;

  typedef logic [31:0] word;
  typedef logic [4:0]  r;
  typedef logic [11:0] csr_addr_t;

  // Register and immediate forms; for the immediate forms `in` already holds
  // the zero-extended uimm and rs1 holds the raw uimm field.
  typedef enum logic [2:0] {
    CsrNone = 3'd0,
    CsrRw   = 3'd1,
    CsrRs   = 3'd2,
    CsrRc   = 3'd3,
    CsrRwi  = 3'd4,
    CsrRsi  = 3'd5,
    CsrRci  = 3'd6
  } csr_t;

  // LED PWM config word: EN | reserved | PRESC | TOP | DUTY
  localparam csr_addr_t LedPwmCsrAddr  = 12'h7c0;
  localparam int        LedPwmEnBit    = 31;
  localparam int        LedPwmPrescLsb = 16;
  localparam int        LedPwmTopLsb   = 8;
  localparam int        LedPwmDutyLsb  = 0;

  typedef enum logic {
    PwmIdle = 1'b0,
    PwmRun  = 1'b1
  } pwm_state_t;

  function automatic logic [7:0] cfg_field(input word cfg, input int lsb);
    return cfg[lsb +: 8];
  endfunction

endpackage

// File: rtl/csr.sv
// Single CSR register with RW/RS/RC semantics (register and immediate forms).
// Ports: clk, reset, en/addr/rs1/rd/op/in (access), old (pre-access value), q (current value).
// Write lands on the clock edge of the access; old is combinational from q.
module csr
  import decoder_pkg::*;
#(
  parameter csr_addr_t Addr     = '0,
  parameter word       ResetVal = '0
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      en,
  input  csr_addr_t addr,
  input  r          rs1,
  input  r          rd,
  input  csr_t      op,
  input  word       in,
  output word       old,
  output word       q
);

  logic hit;
  logic we;
  logic rw_form;
  word  q_nxt;

  assign hit     = en && (addr == Addr);
  assign rw_form = (op == CsrRw) || (op == CsrRwi);

  always_comb begin
    we    = 1'b0;
    q_nxt = q;
    if (hit) begin
      case (op)
        CsrRw, CsrRwi: begin
          we    = 1'b1;
          q_nxt = in;
        end
        // rs1 == x0 (or uimm == 0) makes set/clear a pure read
        CsrRs, CsrRsi: begin
          we    = (rs1 != '0);
          q_nxt = q | in;
        end
        CsrRc, CsrRci: begin
          we    = (rs1 != '0);
          q_nxt = q & ~in;
        end
        default: begin
          we    = 1'b0;
          q_nxt = q;
        end
      endcase
    end
  end

  // A write-only access (rd == x0) performs no read, so nothing is returned.
  assign old = (hit && !(rw_form && (rd == '0))) ? q : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= ResetVal;
    end else if (we) begin
      q <= q_nxt;
    end
  end

endmodule

// File: rtl/pwm_core.sv
// Prescaled period counter with double-buffered PRESC/TOP/DUTY and compare output.
// Ports: clk, reset, cfg (config word, EN|rsvd|PRESC|TOP|DUTY), led (PWM output).
// Shadows reload only on start or at a period boundary, so the output never glitches.
module pwm_core
  import decoder_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  word  cfg,
  output logic led
);

  pwm_state_t state, state_nxt;
  logic [7:0] pcnt, pcnt_nxt;
  logic [7:0] cnt, cnt_nxt;
  logic [7:0] presc_s, presc_nxt;
  logic [7:0] top_s, top_nxt;
  logic [7:0] duty_s, duty_nxt;
  logic       cfg_en;
  logic       tick;
  logic       load;
  logic       cfg_unused;

  assign cfg_en     = cfg[LedPwmEnBit];
  assign tick       = (pcnt == presc_s);
  // reserved bits are storage only
  assign cfg_unused = ^cfg[30:24];

  always_comb begin
    state_nxt = state;
    pcnt_nxt  = pcnt;
    cnt_nxt   = cnt;
    load      = 1'b0;
    case (state)
      PwmIdle: begin
        if (cfg_en) begin
          state_nxt = PwmRun;
          pcnt_nxt  = '0;
          cnt_nxt   = '0;
          load      = 1'b1;
        end
      end
      PwmRun: begin
        if (!cfg_en) begin
          // abort the period at once; shadows are kept
          state_nxt = PwmIdle;
          pcnt_nxt  = '0;
          cnt_nxt   = '0;
        end else if (tick) begin
          pcnt_nxt = '0;
          if (cnt == top_s) begin
            cnt_nxt = '0;
            load    = 1'b1;
          end else begin
            cnt_nxt = cnt + 8'd1;
          end
        end else begin
          pcnt_nxt = pcnt + 8'd1;
        end
      end
      default: begin
        state_nxt = PwmIdle;
        pcnt_nxt  = '0;
        cnt_nxt   = '0;
      end
    endcase
  end

  // cfg is registered, so a write on a boundary edge is only seen next period
  always_comb begin
    presc_nxt = presc_s;
    top_nxt   = top_s;
    duty_nxt  = duty_s;
    if (load) begin
      presc_nxt = cfg_field(cfg, LedPwmPrescLsb);
      top_nxt   = cfg_field(cfg, LedPwmTopLsb);
      duty_nxt  = cfg_field(cfg, LedPwmDutyLsb);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= PwmIdle;
      pcnt    <= '0;
      cnt     <= '0;
      presc_s <= '0;
      top_s   <= '0;
      duty_s  <= '0;
    end else begin
      state   <= state_nxt;
      pcnt    <= pcnt_nxt;
      cnt     <= cnt_nxt;
      presc_s <= presc_nxt;
      top_s   <= top_nxt;
      duty_s  <= duty_nxt;
    end
  end

  // DUTY > TOP gives constant high, DUTY == 0 constant low
  assign led = (state == PwmRun) && (cnt < duty_s);

endmodule

// File: rtl/csr_led_pwm.sv
// CSR-mapped LED PWM/blink driver: config CSR feeding a prescaled PWM core.
// Ports: clk, reset, en/addr/rs1/rd/op/in (CSR access), old (rd writeback), led (pin).
// Config written at edge E0 is acted on at E1; led is registered-state combinational.
module csr_led_pwm
  import decoder_pkg::*;
#(
  parameter csr_addr_t Addr = LedPwmCsrAddr
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      en,
  input  csr_addr_t addr,
  input  r          rs1,
  input  r          rd,
  input  csr_t      op,
  input  word       in,
  output word       old,
  output logic      led
);

  word cfg;

  csr #(
    .Addr     (Addr),
    .ResetVal ('0)
  ) u_csr (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .addr  (addr),
    .rs1   (rs1),
    .rd    (rd),
    .op    (op),
    .in    (in),
    .old   (old),
    .q     (cfg)
  );

  pwm_core u_pwm (
    .clk   (clk),
    .reset (reset),
    .cfg   (cfg),
    .led   (led)
  );

endmodule

// File: tb/tb_csr_led_pwm.sv
// Self-checking bench for csr_led_pwm: expected led per cycle queued, popped each cycle.
module tb_csr_led_pwm;
  import decoder_pkg::*;

  localparam csr_addr_t A = LedPwmCsrAddr;

  logic      clk;
  logic      reset;
  logic      en;
  csr_addr_t addr;
  r          rs1;
  r          rd;
  csr_t      op;
  word       in;
  word       old;
  logic      led;

  int   n_tests;
  int   n_fail;
  int   idx;
  string cur_tag;
  logic sb[$];

  csr_led_pwm #(.Addr(A)) dut (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .addr  (addr),
    .rs1   (rs1),
    .rd    (rd),
    .op    (op),
    .in    (in),
    .old   (old),
    .led   (led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Present a CSR access for the next edge and check the combinational old.
  task automatic csr_req(input string tag, input csr_t o, input word v, input r s1,
                         input csr_addr_t a, input bit chk_old, input word exp_old);
    en   = 1'b1;
    op   = o;
    in   = v;
    rs1  = s1;
    rd   = 5'd5;
    addr = a;
    #1;
    if (chk_old) chk({tag, " old"}, old, exp_old);
  endtask

  // One clock: sample just after the edge, compare against the scoreboard head.
  task automatic cycle();
    logic e;
    @(posedge clk);
    #1;
    en = 1'b0;
    op = CsrNone;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk($sformatf("%s led[%0d]", cur_tag, idx), {31'b0, led}, {31'b0, e});
      idx++;
    end
  endtask

  task automatic drain();
    while (sb.size() > 0) cycle();
  endtask

  task automatic push_const(input logic v, input int n);
    for (int i = 0; i < n; i++) sb.push_back(v);
  endtask

  // Steady-state waveform: step = k/(PRESC+1), position in period = step mod (TOP+1).
  task automatic push_run(input int p, input int t, input int d, input int k0, input int n);
    for (int k = k0; k < k0 + n; k++) sb.push_back(((k / (p + 1)) % (t + 1)) < d);
  endtask

  task automatic start(input string tag);
    cur_tag = tag;
    idx     = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycle();
    cycle();
    reset = 1'b0;
  endtask

  // Reset, write cfg with CSRRW, then expect the given steady waveform.
  task automatic run_pattern(input string tag, input word v, input int n);
    int p, t, d;
    p = int'(v[23:16]);
    t = int'(v[15:8]);
    d = int'(v[7:0]);
    do_reset();
    start(tag);
    csr_req(tag, CsrRw, v, 5'd1, A, 1'b1, 32'h0);
    sb.push_back(1'b0);            // write edge: not yet running
    push_run(p, t, d, 0, n);
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b1;
    en      = 1'b0;
    addr    = A;
    rs1     = '0;
    rd      = '0;
    op      = CsrNone;
    in      = '0;
    do_reset();

    // reset state
    start("reset");
    chk("reset led", {31'b0, led}, 32'h0);
    csr_req("reset rd", CsrRs, 32'hffff_ffff, 5'd0, A, 1'b1, 32'h0);
    cycle();

    // enable and run / prescaler / limits / single-cycle period
    run_pattern("p0t3d2", 32'h8000_0302, 12);
    run_pattern("p1t3d1", 32'h8001_0301, 16);
    run_pattern("duty0", 32'h8000_0300, 8);
    run_pattern("duty_gt_top", 32'h8000_0304, 8);
    run_pattern("t0p0d5", 32'h8000_0005, 4);
    run_pattern("p2t2d2", 32'h8002_0202, 18);

    // mid-period duty update takes effect at the next boundary
    do_reset();
    start("midupd");
    csr_req("midupd wr", CsrRw, 32'h8000_0701, 5'd1, A, 1'b1, 32'h0);
    sb.push_back(1'b0);
    push_run(0, 7, 1, 0, 3);
    drain();                       // now cnt == 2
    csr_req("midupd rs", CsrRs, 32'h0000_0006, 5'd3, A, 1'b1, 32'h8000_0701);
    push_const(1'b0, 5);           // rest of old period, cnt 3..7
    push_run(0, 7, 7, 0, 16);
    drain();
    csr_req("midupd rb", CsrRs, 32'h0, 5'd0, A, 1'b1, 32'h8000_0707);
    cycle();

    // disable in high phase, then re-enable from cnt 0
    do_reset();
    start("disable");
    csr_req("dis wr", CsrRw, 32'h8000_0302, 5'd1, A, 1'b1, 32'h0);
    sb.push_back(1'b0);
    sb.push_back(1'b1);
    drain();
    csr_req("dis rc", CsrRc, 32'h8000_0000, 5'd2, A, 1'b1, 32'h8000_0302);
    sb.push_back(1'b1);            // EN still seen as 1 at the write edge
    push_const(1'b0, 3);
    drain();
    start("reenable");
    csr_req("reen rs", CsrRs, 32'h8000_0000, 5'd2, A, 1'b1, 32'h0000_0302);
    sb.push_back(1'b0);
    push_run(0, 3, 2, 0, 8);
    drain();

    // reset mid-period
    do_reset();
    start("midreset");
    csr_req("mr wr", CsrRw, 32'h8000_0302, 5'd1, A, 1'b1, 32'h0);
    sb.push_back(1'b0);
    sb.push_back(1'b1);
    drain();
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("midreset led", {31'b0, led}, 32'h0);
    reset = 1'b0;
    csr_req("midreset cfg", CsrRs, 32'h0, 5'd0, A, 1'b1, 32'h0);
    push_const(1'b0, 4);
    drain();

    // decode: foreign address, read-only set/clear forms
    do_reset();
    start("decode");
    csr_req("foreign", CsrRw, 32'h8000_0302, 5'd1, A + 12'd1, 1'b0, 32'h0);
    push_const(1'b0, 4);
    drain();
    csr_req("foreign rb", CsrRs, 32'h0, 5'd0, A, 1'b1, 32'h0);
    cycle();
    csr_req("dec wr", CsrRw, 32'h8000_0302, 5'd1, A, 1'b1, 32'h0);
    cycle();
    csr_req("rs x0", CsrRs, 32'hffff_ffff, 5'd0, A, 1'b1, 32'h8000_0302);
    cycle();
    csr_req("rc x0", CsrRc, 32'hffff_ffff, 5'd0, A, 1'b1, 32'h8000_0302);
    cycle();
    csr_req("rsi 0", CsrRsi, 32'h0000_001f, 5'd0, A, 1'b1, 32'h8000_0302);
    cycle();
    csr_req("ro rb", CsrRs, 32'h0, 5'd0, A, 1'b1, 32'h8000_0302);
    cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
